// File: rtl/rob_retire.sv
// rob_retire: reorder buffer with in-order retire to the rename free list.
// Purpose : tracks renamed instructions, marks them done on completion
//           (phys-reg CAM) and retires them in program order, one per cycle.
// Ports   : clk, reset_n (async, active-low)
//           alloc_*    : one renamed instruction per cycle from rename
//           complete_* : physical register written back this cycle
//           retire_*   : registered retire pulse and data (old phys to free list)
//           alloc_tag, rob_count, rob_full, rob_empty, overflow_err : status
//           retire_count : retired-instruction counter
// Option  : define ROB_RETIRE_COUNT_EN to build the retire counter;
//           otherwise retire_count is tied to 0.
module rob_retire #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     alloc_valid,
    input  logic [4:0]               alloc_arch_rd,
    input  logic [5:0]               alloc_phys_rd,
    input  logic [5:0]               alloc_old_phys_rd,
    input  logic                     complete_valid,
    input  logic [5:0]               complete_phys_reg,
    output logic                     retire_valid,
    output logic [5:0]               retire_phys_reg,
    output logic [4:0]               retire_arch_reg,
    output logic [5:0]               retire_new_phys_reg,
    output logic [$clog2(DEPTH)-1:0] alloc_tag,
    output logic [$clog2(DEPTH):0]   rob_count,
    output logic                     rob_full,
    output logic                     rob_empty,
    output logic                     overflow_err,
    output logic [31:0]              retire_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] done_q, done_d;
    logic [DEPTH-1:0] match;
    logic [4:0]       arch_q [DEPTH];
    logic [5:0]       phys_q [DEPTH];
    logic [5:0]       old_q  [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full_q, empty_q, ovf_q;

    logic             rv_q;
    logic [5:0]       rphys_q, rnew_q;
    logic [4:0]       rarch_q;

    logic             is_full;
    logic             acc;
    logic             ret;
    logic             byp;

    // Full is judged from the pre-edge count, so a same-cycle retire
    // does not make room for an allocation.
    assign is_full = (count_q == (PTR_W+1)'(DEPTH));
    assign acc     = alloc_valid && !is_full;
    assign ret     = valid_q[head_q] && done_q[head_q];
    assign byp     = complete_valid &&
                     (complete_phys_reg == alloc_phys_rd);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = complete_valid && valid_q[i] &&
                       (phys_q[i] == complete_phys_reg);
        end
    end

    // Head and tail only coincide when empty or full, so the retire
    // clear and the allocate write never target the same slot.
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q | match;
        head_d  = head_q;
        tail_d  = tail_q;
        if (ret) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (acc) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = byp;
            tail_d          = tail_q + PTR_W'(1);
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({acc, ret})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= (count_d == (PTR_W+1)'(DEPTH));
            empty_q <= (count_d == '0);
            if (alloc_valid && is_full) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Payload needs no reset: it is qualified by valid_q.
    always_ff @(posedge clk) begin
        if (acc) begin
            arch_q[tail_q] <= alloc_arch_rd;
            phys_q[tail_q] <= alloc_phys_rd;
            old_q[tail_q]  <= alloc_old_phys_rd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rv_q    <= 1'b0;
            rphys_q <= '0;
            rarch_q <= '0;
            rnew_q  <= '0;
        end else begin
            rv_q <= ret;
            if (ret) begin
                rphys_q <= old_q[head_q];
                rarch_q <= arch_q[head_q];
                rnew_q  <= phys_q[head_q];
            end
        end
    end

`ifdef ROB_RETIRE_COUNT_EN
    logic [31:0] rcnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rcnt_q <= '0;
        end else if (ret) begin
            rcnt_q <= rcnt_q + 32'd1;
        end
    end

    assign retire_count = rcnt_q;
`else
    assign retire_count = '0;
`endif

    assign retire_valid        = rv_q;
    assign retire_phys_reg     = rphys_q;
    assign retire_arch_reg     = rarch_q;
    assign retire_new_phys_reg = rnew_q;
    assign alloc_tag           = tail_q;
    assign rob_count           = count_q;
    assign rob_full            = full_q;
    assign rob_empty           = empty_q;
    assign overflow_err        = ovf_q;

endmodule
